vga_scanout: RTL and testbench

//  Single-clock VGA scan-out stage downstream of the double framebuffer, running in the pixel (read) clock domain.

---
 rtl/color_pkg.sv | 4 +
 rtl/vga_pkg.sv | 28 ++
 rtl/vga_scanout_if.sv | 29 ++
 rtl/vga_timing.sv | 60 ++++++
 rtl/vga_scanout.sv | 123 ++++++++++++
 tb/tb_vga_scanout.sv | 166 ++++++++++++++++
 6 files changed

// File: rtl/color_pkg.sv
// Shared colour types for the display path.
package color_pkg;
  typedef logic [11:0] color12_t;   // {r[3:0], g[3:0], b[3:0]}
endpackage

// File: rtl/vga_pkg.sv
// VGA 640x480@60 timing defaults, the sync bundle carried down the alignment delay line,
// and the colour-bar helper used by the optional test pattern.
package vga_pkg;
  import color_pkg::*;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int H_TOTAL      = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL      = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef struct packed {
    logic hsync_n;
    logic vsync_n;
    logic active;
  } vga_sync_t;

  localparam vga_sync_t SYNC_IDLE = '{hsync_n: 1'b1, vsync_n: 1'b1, active: 1'b0};

  function automatic color12_t bar_rgb(input logic [2:0] bar);
    return {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
  endfunction
endpackage

// File: rtl/vga_scanout_if.sv
// Framebuffer read port plus VGA pin bundle; master = scan-out, slave = framebuffer/board side.
interface vga_scanout_if #(
  parameter int X_W = 8,
  parameter int Y_W = 7
);
  import color_pkg::*;

  logic [X_W-1:0] read_x;
  logic [Y_W-1:0] read_y;
  color12_t       read_data;
  logic           test_pattern;
  logic [3:0]     vga_r;
  logic [3:0]     vga_g;
  logic [3:0]     vga_b;
  logic           vga_hsync;
  logic           vga_vsync;
  logic           frame_start;
  logic           vblank;

  modport master (
    output read_x, read_y, vga_r, vga_g, vga_b, vga_hsync, vga_vsync, frame_start, vblank,
    input  read_data, test_pattern
  );

  modport slave (
    input  read_x, read_y, vga_r, vga_g, vga_b, vga_hsync, vga_vsync, frame_start, vblank,
    output read_data, test_pattern
  );
endinterface

// File: rtl/vga_timing.sv
// Raster counters with next-value outputs, cycle-0 active/sync decode, and the undelayed
// frame_start pulse (only on a counter wrap, so never straight out of reset) and vblank level.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int HCW      = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int VCW      = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic           clk,
  input  logic           rst,
  output logic [HCW-1:0] hcount,
  output logic [VCW-1:0] vcount,
  output logic [HCW-1:0] h_next,
  output logic [VCW-1:0] v_next,
  output vga_sync_t      sync,
  output logic           frame_start,
  output logic           vblank
);
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  always_comb begin
    h_next = hcount + 1'b1;
    v_next = vcount;
    if (hcount == HCW'(HT - 1)) begin
      h_next = '0;
      v_next = (vcount == VCW'(VT - 1)) ? '0 : vcount + 1'b1;
    end
  end

  always_comb begin
    sync.active  = (hcount < HCW'(H_ACTIVE)) && (vcount < VCW'(V_ACTIVE));
    sync.hsync_n = !((hcount >= HCW'(H_ACTIVE + H_FP)) &&
                     (hcount <  HCW'(H_ACTIVE + H_FP + H_SYNC)));
    sync.vsync_n = !((vcount >= VCW'(V_ACTIVE + V_FP)) &&
                     (vcount <  VCW'(V_ACTIVE + V_FP + V_SYNC)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount      <= '0;
      vcount      <= '0;
      frame_start <= 1'b0;
      vblank      <= 1'b0;
    end else begin
      hcount      <= h_next;
      vcount      <= v_next;
      frame_start <= (h_next == '0) && (v_next == '0);
      vblank      <= v_next >= VCW'(V_ACTIVE);
    end
  end
endmodule

// File: rtl/vga_scanout.sv
// VGA scan-out: framebuffer address generation with 2^SCALE_SHIFT upscaling, sync delayed to meet
// read_data, registered pins (counter->pin latency READ_LATENCY+1). Optional bars: VGA_TEST_PATTERN_EN.
module vga_scanout
  import color_pkg::*;
  import vga_pkg::*;
#(
  parameter int H_ACTIVE     = DEF_H_ACTIVE,
  parameter int H_FP         = DEF_H_FP,
  parameter int H_SYNC       = DEF_H_SYNC,
  parameter int H_BP         = DEF_H_BP,
  parameter int V_ACTIVE     = DEF_V_ACTIVE,
  parameter int V_FP         = DEF_V_FP,
  parameter int V_SYNC       = DEF_V_SYNC,
  parameter int V_BP         = DEF_V_BP,
  parameter int FB_WIDTH     = 160,
  parameter int FB_HEIGHT    = 120,
  parameter int SCALE_SHIFT  = 2,
  parameter int READ_LATENCY = 2
) (
  input  logic          clk_read,
  input  logic          rst,
  vga_scanout_if.master bus
);
  localparam int HCW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int VCW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam int XW  = $clog2(FB_WIDTH);
  localparam int YW  = $clog2(FB_HEIGHT);

  logic [HCW-1:0] hcount, h_next;
  logic [VCW-1:0] vcount, v_next;
  vga_sync_t      sync;
  logic           nxt_active;
  logic [XW-1:0]  read_x;
  logic [YW-1:0]  read_y;
  vga_sync_t      dly [READ_LATENCY];
  color12_t       pix;
  color12_t       rgb;
  logic           hsync_q, vsync_q;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HCW(HCW), .VCW(VCW)
  ) u_timing (
    .clk         (clk_read),
    .rst         (rst),
    .hcount      (hcount),
    .vcount      (vcount),
    .h_next      (h_next),
    .v_next      (v_next),
    .sync        (sync),
    .frame_start (bus.frame_start),
    .vblank      (bus.vblank)
  );

  // Address is computed from the next counter value so it lands alongside that counter value.
  assign nxt_active = (h_next < HCW'(H_ACTIVE)) && (v_next < VCW'(V_ACTIVE));

  always_ff @(posedge clk_read) begin
    if (rst) begin
      read_x <= '0;
      read_y <= '0;
    end else begin
      read_x <= nxt_active ? XW'(h_next >> SCALE_SHIFT) : '0;
      read_y <= nxt_active ? YW'(v_next >> SCALE_SHIFT) : '0;
    end
  end

  always_ff @(posedge clk_read) begin
    if (rst) begin
      for (int i = 0; i < READ_LATENCY; i++) dly[i] <= SYNC_IDLE;
    end else begin
      dly[0] <= sync;
      for (int i = 1; i < READ_LATENCY; i++) dly[i] <= dly[i-1];
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  logic [HCW-1:0] hdly [READ_LATENCY];

  always_ff @(posedge clk_read) begin
    if (rst) begin
      for (int i = 0; i < READ_LATENCY; i++) hdly[i] <= '0;
    end else begin
      hdly[0] <= hcount;
      for (int i = 1; i < READ_LATENCY; i++) hdly[i] <= hdly[i-1];
    end
  end

  // Eight equal-width bars across the active line.
  always_comb begin
    pix = bus.read_data;
    if (bus.test_pattern) pix = bar_rgb(3'(hdly[READ_LATENCY-1] / HCW'(H_ACTIVE / 8)));
  end
`else
  logic unused_tp;
  assign unused_tp = ^{bus.test_pattern, hcount, vcount};

  always_comb begin
    pix = bus.read_data;
  end
`endif

  always_ff @(posedge clk_read) begin
    if (rst) begin
      rgb     <= 12'h000;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      rgb     <= dly[READ_LATENCY-1].active ? pix : 12'h000;
      hsync_q <= dly[READ_LATENCY-1].hsync_n;
      vsync_q <= dly[READ_LATENCY-1].vsync_n;
    end
  end

  assign bus.read_x    = read_x;
  assign bus.read_y    = read_y;
  assign bus.vga_r     = rgb[11:8];
  assign bus.vga_g     = rgb[7:4];
  assign bus.vga_b     = rgb[3:0];
  assign bus.vga_hsync = hsync_q;
  assign bus.vga_vsync = vsync_q;
endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench: full-size instance for line-level timing/pixels, shrunken-timing instance
// (24x12 raster, 288 clks/frame) for vertical sync, frame_start period and mid-frame reset.
module tb_vga_scanout;
  import color_pkg::*;

  bit clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst_s, hold, tp;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  vga_scanout_if #(.X_W(8), .Y_W(7)) bus ();
  vga_scanout_if #(.X_W(2), .Y_W(1)) bus_s ();

  vga_scanout u_dut (.clk_read(clk), .rst(rst), .bus(bus));

  vga_scanout #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .FB_WIDTH(4), .FB_HEIGHT(2)
  ) u_small (.clk_read(clk), .rst(rst_s), .bus(bus_s));

  // Framebuffer model: two-cycle read latency, pixel {x[3:0], y[3:0], 4'h5}.
  color12_t fb_q1, fb_q2;
  always @(posedge clk) begin
    fb_q1 <= {bus.read_x[3:0], bus.read_y[3:0], 4'h5};
    fb_q2 <= fb_q1;
  end
  assign bus.read_data      = hold ? 12'hFFF : fb_q2;
  assign bus.test_pattern   = tp;
  assign bus_s.read_data    = 12'hABC;
  assign bus_s.test_pattern = 1'b0;

  logic [11:0] rgb, rgb_s;
  assign rgb   = {bus.vga_r, bus.vga_g, bus.vga_b};
  assign rgb_s = {bus_s.vga_r, bus_s.vga_g, bus_s.vga_b};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance to cycle c (counter value c since last release) and settle 1 time unit past the edge.
  task automatic to(input int c);
    repeat (c - cyc) @(posedge clk);
    cyc = c;
    #1;
  endtask

  initial begin
    int hl, act, fff, zer, perr, rise, first_act;
    logic prev_h;
    logic [11:0] exp_px;

    rst = 1'b1; rst_s = 1'b1; hold = 1'b0; tp = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hsync", bus.vga_hsync, 1);
    chk("rst_vsync", bus.vga_vsync, 1);
    chk("rst_rgb", rgb, 0);
    chk("rst_fs", bus.frame_start, 0);
    chk("rst_vblank", bus.vblank, 0);
    chk("rst_rx", bus.read_x, 0);
    chk("rst_ry", bus.read_y, 0);
    chk("rst_s_vsync", bus_s.vga_vsync, 1);

    rst = 1'b0; rst_s = 1'b0; cyc = 0;
    chk("c0_rx", bus.read_x, 0);
    chk("c0_hsync", bus.vga_hsync, 1);
    chk("c0_fs", bus_s.frame_start, 0);
    to(2);  chk("lat_rgb_c2", rgb, 12'h000);
    to(3);  chk("lat_rgb_c3", rgb, 12'h005);
    to(5);  chk("rx_h5", bus.read_x, 1);
    to(10); chk("rgb_h7", rgb, 12'h105);
    to(20); chk("s_hs_h17", bus_s.vga_hsync, 1);
    to(21); chk("s_hs_h18", bus_s.vga_hsync, 0);
    to(24); chk("s_hs_h21", bus_s.vga_hsync, 0);
    to(25); chk("s_hs_h22", bus_s.vga_hsync, 1);
    to(191); chk("s_vblank_v7", bus_s.vblank, 0);
    to(192); chk("s_vblank_v8", bus_s.vblank, 1);
    to(218); chk("s_vs_pre", bus_s.vga_vsync, 1);
    to(219); chk("s_vs_fall", bus_s.vga_vsync, 0);
    to(266); chk("s_vs_last", bus_s.vga_vsync, 0);
    to(267); chk("s_vs_rise", bus_s.vga_vsync, 1);
    to(287); chk("s_fs_287", bus_s.frame_start, 0); chk("s_vblank_287", bus_s.vblank, 1);
    to(288); chk("s_fs_288", bus_s.frame_start, 1); chk("s_vblank_288", bus_s.vblank, 0);
    to(289); chk("s_fs_289", bus_s.frame_start, 0);
    to(576); chk("s_fs_576", bus_s.frame_start, 1);
    to(642); chk("rgb_h639", rgb, 12'hF05);
    to(643); chk("rgb_h640_blank", rgb, 12'h000);

    // Pins 644..1602: hsync edge vs next active run, then one full line (counter line 1).
    hl = 0; act = 0; perr = 0; rise = -1; first_act = -1; prev_h = bus.vga_hsync;
    for (int c = 644; c <= 1602; c++) begin
      to(c);
      if (c == 659) chk("hs_fall", bus.vga_hsync, 0);
      if (c == 755) chk("hs_rise", bus.vga_hsync, 1);
      if (!prev_h && bus.vga_hsync && rise < 0) rise = c;
      if (rgb != 0 && first_act < 0) first_act = c;
      prev_h = bus.vga_hsync;
      if (c >= 803) begin
        if (!bus.vga_hsync) hl++;
        if (rgb != 0) act++;
        exp_px = (c <= 1442) ? {4'((c - 803) >> 2), 4'h0, 4'h5} : 12'h000;
        if (rgb !== exp_px) perr++;
      end
    end
    chk("hs_low_clks", hl, 96);
    chk("active_clks", act, 640);
    chk("line1_pixels_bad", perr, 0);
    chk("hsrise_to_active", first_act - rise, 48);
    chk("blank_run", first_act - 643, 160);

    to(4103); chk("rgb_v5_h100", rgb, 12'h915);

    to(4200); hold = 1'b1;
    fff = 0; zer = 0;
    for (int c = 4803; c <= 5602; c++) begin
      to(c);
      if (rgb == 12'hFFF) fff++;
      if (rgb == 12'h000) zer++;
    end
    chk("hold_fff_clks", fff, 640);
    chk("hold_blank_clks", zer, 160);

    // Small instance: counter at (h5, v10) inside vsync; reset 3 clocks.
    to(5717); chk("s_pre_vs", bus_s.vga_vsync, 0); chk("s_pre_vblank", bus_s.vblank, 1);
    rst_s = 1'b1;
    to(5720);
    chk("s_mr_hsync", bus_s.vga_hsync, 1);
    chk("s_mr_vsync", bus_s.vga_vsync, 1);
    chk("s_mr_rgb", rgb_s, 0);
    chk("s_mr_fs", bus_s.frame_start, 0);
    chk("s_mr_vblank", bus_s.vblank, 0);
    rst_s = 1'b0;
    chk("s_mr_rx", bus_s.read_x, 0);
    to(5722); chk("s_rel_rgb2", rgb_s, 0); chk("s_rel_vs2", bus_s.vga_vsync, 1);
    to(5723); chk("s_rel_rgb3", rgb_s, 12'hABC);
    to(5725); chk("s_rel_rx5", bus_s.read_x, 1);
    to(6007); chk("s_rel_fs287", bus_s.frame_start, 0);
    to(6008); chk("s_rel_fs288", bus_s.frame_start, 1);

    tp = 1'b1;
`ifdef VGA_TEST_PATTERN_EN
    to(6403); chk("tp_h0", rgb, 12'h000);
    to(6483); chk("tp_h80", rgb, 12'h00F);
    to(6643); chk("tp_h240", rgb, 12'h0FF);
    to(7042); chk("tp_h639", rgb, 12'hFFF);
`else
    to(6403); chk("tp_off_h0", rgb, 12'hFFF);
    to(6483); chk("tp_off_h80", rgb, 12'hFFF);
    to(6643); chk("tp_off_h240", rgb, 12'hFFF);
    to(7042); chk("tp_off_h639", rgb, 12'hFFF);
`endif
    to(7043); chk("tp_blank_h640", rgb, 12'h000);
    tp = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
